uart_tx: RTL
============

Name: uart_tx

Overview:
UART transmitter for the SoC's serial console path. It serialises one byte per handshake onto `tx` as 8N1 framing: start bit, 8 data bits LSB first, STOP_BITS stop bits. Its CPU-side handshake mirrors the existing receiver's (`go` held high until `done`, then `go` released), so the UART peripheral wrapper drives both ends the same way.

Parameters:
- CLK_FREQ, 66_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits per second. BIT_TIME = CLK_FREQ / BAUD_RATE (integer division); BIT_TIME >= 1 required.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- data  input  8  byte to send; sampled only in the cycle `go` is accepted.
- go  input  1  request to send; held high by CPU until `done` is seen.
- tx  output  1  serial line, idle high.
- bsy  output  1  frame in progress.
- done  output  1  frame finished; held until `go` is low.

Behaviour:
- Reset (rst=0, async): tx=1, bsy=0, done=0, state=IDLE, shift register=0, counters=0. Reset mid-frame aborts immediately; no partial frame resumes.
- Bit counter width: max(1, clog2(BIT_TIME)). Every bit lasts exactly BIT_TIME clocks. The counter loads BIT_TIME-1 and decrements to 0.
- States:
  - IDLE → START
  - START → DATA
  - DATA → (PARITY) → STOP
  - STOP → WAIT_GO_LOW
  - WAIT_GO_LOW → IDLE
- IDLE: tx=1. If go=1, latch `data` into the shift register, set tx=0 and bsy=1 (both registered, visible the cycle after go is sampled), and go to START.
- START: tx=0 for BIT_TIME cycles, then drive data bit 0.
- DATA: shift out LSB first. The bit index counts 0..7; after bit 7's BIT_TIME expires, go to STOP (or PARITY if enabled).
- STOP: tx=1 for STOP_BITS*BIT_TIME cycles. At expiry: done=1, bsy=0, go to WAIT_GO_LOW.
- WAIT_GO_LOW: tx=1. When go=0: done=0 and return to IDLE. A new frame cannot start before go has been seen low.
- Total latency from go sampled to done high: (1+8+STOP_BITS)*BIT_TIME + 1 cycles.
- `data` changes while bsy=1 are ignored.
- go dropped mid-frame: the frame still completes. done is then high for exactly one cycle, because WAIT_GO_LOW sees go=0 at once.
- go high continuously after done: no retransmit; the block stays in WAIT_GO_LOW.
- BIT_TIME=1: each bit is one cycle; no special-case path is needed beyond the counter width rule.
- tx is a registered output, glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP lasting BIT_TIME cycles. tx = XOR of the 8 data bits (even parity), inverted when parameter PARITY_ODD (default 0) is 1. Latency grows by BIT_TIME.
- Undefined: no PARITY state, no PARITY_ODD parameter, pure 8N1.

Decomposition:
- Shared uart include/package: state encodings (IDLE, START, DATA, PARITY, STOP, WAIT_GO_LOW) and the BIT_TIME / counter-width calculation, so receiver and transmitter agree.
- One natural sub-module: uart_bit_timer. It is loadable with BIT_TIME-1, decrements to 0, asserts `expire`, and is reused later by the receiver refactor.

Test Plan:
- Reset: hold rst=0 for 5 cycles with go=1 → tx=1, bsy=0, done=0 throughout. Release → frame starts next cycle.
- CLK_FREQ=4, BAUD_RATE=1 (BIT_TIME=4), data=0x55, go=1 → tx sequence in 4-cycle bits: 0,1,0,1,0,1,0,1,0,1. done rises 41 cycles after go sampled; drop go → done=0 next cycle, tx=1.
- BIT_TIME=1, data=0xA3 → tx = 0,1,1,0,0,0,1,0,1,1 on consecutive cycles. done on cycle 11.
- Change data to 0xFF at mid-frame of 0x00 send → frame still all zeros. Then hold go=1 after done → no second start bit for 100 cycles.
- Assert rst=0 during bit 3 of 0x0F → tx=1 in the same cycle (async), bsy=0. After release with go=1, a complete new frame follows.
- With UART_TX_PARITY_EN, BIT_TIME=4, data=0x07, PARITY_ODD=0 → parity bit=1 before stop. With PARITY_ODD=1 → parity bit=0. done latency=45 cycles.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing arithmetic.
// The transmitter and receiver both import this package so their state
// names and counter sizing always agree.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START       = 3'd1,
        DATA        = 3'd2,
        PARITY      = 3'd3,
        STOP        = 3'd4,
        WAIT_GO_LOW = 3'd5
    } uart_state_e;

    // Clocks per serial bit (integer division).
    function automatic int calc_bit_time(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Counter width able to hold BIT_TIME-1; never narrower than one bit.
    function automatic int cnt_width(input int bit_time);
        return (bit_time > 2) ? $clog2(bit_time) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side handshake of the UART transmitter: byte, go/done request pair
// and busy flag. The serial line itself is a plain port on the block.
interface uart_tx_if;
    logic [7:0] data;
    logic       go;
    logic       bsy;
    logic       done;

    modport master (output data, go, input bsy, done);
    modport slave  (input data, go, output bsy, done);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_bit_timer: down-counter that times one serial bit. Loading sets it
// to BIT_TIME-1; it then counts down and holds at zero, where expire_o is
// high. Shared with the receiver.
module uart_bit_timer
    import uart_tx_pkg::*;
#(
    parameter int BIT_TIME = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic expire_o
);
    localparam int               CNT_W    = cnt_width(BIT_TIME);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BIT_TIME - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count register: reload on request, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (start bit, 8 data bits LSB first,
// STOP_BITS stop bits). Handshake: go held until done, then released.
// Optional build macro UART_TX_PARITY_EN inserts an even/odd parity bit
// (parameter PARITY_ODD) between the data bits and the stop bits.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 66_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic        clk,
    input  logic        rst,
    uart_tx_if.slave    bus,
    output logic        tx
);
    localparam int BIT_TIME = calc_bit_time(CLK_FREQ, BAUD_RATE);

    uart_state_e state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  idx_q, idx_d;     // data bit index, reused as stop bit index
    logic        tx_q, tx_d;
    logic        bsy_q, bsy_d;
    logic        done_q, done_d;
    logic        load;
    logic        expire;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    uart_bit_timer #(.BIT_TIME(BIT_TIME)) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .expire_o (expire)
    );

    // State and datapath registers; reset aborts any frame in progress.
    // NOTE: the shift register is a handful of flops, not a memory, so it is
    // reset along with the rest; sequential state uses <= only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            bsy_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            bsy_q   <= bsy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; the next tx level is computed here and registered.
    // NOTE: every signal gets a hold/default value first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        bsy_d   = bsy_q;
        done_d  = done_q;
        load    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.go) begin
                    shreg_d = bus.data;
                    tx_d    = 1'b0;
                    bsy_d   = 1'b1;
                    load    = 1'b1;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^bus.data;
`endif
                end
            end
            START: begin
                if (expire) begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    idx_d   = '0;
                    load    = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (expire) begin
                    load = 1'b1;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q ^ PARITY_ODD;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (expire) begin
                    tx_d    = 1'b1;
                    load    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (expire) begin
                    if (idx_q == 3'(STOP_BITS - 1)) begin
                        done_d  = 1'b1;
                        bsy_d   = 1'b0;
                        state_d = WAIT_GO_LOW;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        load  = 1'b1;
                    end
                end
            end
            WAIT_GO_LOW: begin
                tx_d = 1'b1;
                if (!bus.go) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                bsy_d   = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign tx       = tx_q;
    assign bus.bsy  = bsy_q;
    assign bus.done = done_q;

endmodule
